// File: rtl/enc16_req.sv
// enc16_req: registered 16-to-4 request encoder with valid/ack handshake.
// Ports: clk, rst_n, en, req[15:0], ack -> code[3:0], valid, err, pend[15:0].
module enc16_req (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        ack,
  output logic [3:0]  code,
  output logic        valid,
  output logic        err,
  output logic [15:0] pend
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  r_state;
  logic [3:0]  r_code;
  logic        r_err;
  logic [15:0] r_pend;

  logic [15:0] w_clr;
  logic [15:0] w_set;
  logic [3:0]  w_low;
  logic        w_multi;

  // Only an accepted handshake clears its bit.
  assign w_clr = (r_state == HOLD && ack) ? (16'h0001 << r_code) : 16'h0000;
  assign w_set = en ? req : 16'h0000;

  // req & (req-1) is nonzero iff two or more bits are set.
  assign w_multi = en && ((req & (req - 16'h0001)) != 16'h0000);

  // Scan from the top so the lowest set index wins.
  always_comb begin
    w_low = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (r_pend[i]) w_low = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_code  <= 4'h0;
      r_err   <= 1'b0;
      r_pend  <= 16'h0000;
    end else begin
      // Set after clear: a re-request in the ack cycle stays pending.
      r_pend <= (r_pend & ~w_clr) | w_set;
      r_err  <= w_multi;
      unique case (r_state)
        IDLE: begin
          if (r_pend != 16'h0000) begin
            r_code  <= w_low;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (ack) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign code  = r_code;
  assign valid = (r_state == HOLD);
  assign err   = r_err;
  assign pend  = r_pend;

endmodule

// File: tb/tb_enc16_req.sv
// tb_enc16_req: directed plus random checks of enc16_req
// against a behavioural model of the request/handshake rules.
module tb_enc16_req;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic        err;
  logic [15:0] pend;

  int n_vec;
  int n_bad;

  logic [15:0] m_pend;
  logic [3:0]  m_code;
  logic        m_valid;
  logic        m_err;

  enc16_req dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .ack   (ack),
    .code  (code),
    .valid (valid),
    .err   (err),
    .pend  (pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] lowest(input logic [15:0] p);
    for (int i = 0; i < 16; i++) begin
      if (p[i]) return 4'(i);
    end
    return 4'h0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("code", 16'(code), 16'(m_code));
    chk("valid", 16'(valid), 16'(m_valid));
    chk("err", 16'(err), 16'(m_err));
    chk("pend", pend, m_pend);
  endtask

  task automatic model_reset();
    m_pend  = 16'h0000;
    m_code  = 4'h0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock: apply inputs, advance the model, check outputs.
  task automatic step(input logic e, input logic [15:0] r, input logic a);
    logic [15:0] clr;
    en  = e;
    req = r;
    ack = a;
    @(posedge clk);
    clr = (m_valid && a) ? (16'h0001 << m_code) : 16'h0000;
    if (!m_valid) begin
      if (m_pend != 16'h0000) begin
        m_code  = lowest(m_pend);
        m_valid = 1'b1;
      end
    end else if (a) begin
      m_valid = 1'b0;
    end
    m_err  = e && ($countones(r) >= 2);
    m_pend = (m_pend & ~clr) | (e ? r : 16'h0000);
    #1;
    chk_all();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 16'h0000;
    ack   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;

    // single request
    step(1'b1, 16'h0020, 1'b0);
    chk("pend_0020", pend, 16'h0020);
    step(1'b0, 16'h0000, 1'b0);
    chk("code5", 16'(code), 16'h0005);
    repeat (5) step(1'b0, 16'h0000, 1'b0);
    chk("code5_hold", 16'(code), 16'h0005);
    step(1'b0, 16'h0000, 1'b1);
    chk("pend_drained", pend, 16'h0000);

    // multi-hot priority and drain
    step(1'b1, 16'h8101, 1'b0);
    chk("err_multi", 16'(err), 16'h0001);
    repeat (8) step(1'b0, 16'h0000, m_valid);
    chk("pend_end", pend, 16'h0000);

    // no pre-emption in HOLD
    step(1'b1, 16'h0200, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("code9", 16'(code), 16'h0009);
    step(1'b1, 16'h0002, 1'b0);
    repeat (2) step(1'b0, 16'h0000, 1'b0);
    chk("code9_kept", 16'(code), 16'h0009);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    chk("code1", 16'(code), 16'h0001);
    step(1'b0, 16'h0000, 1'b1);

    // set wins over ack clear
    step(1'b1, 16'h0008, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h0008, 1'b1);
    chk("setwins", pend, 16'h0008);
    step(1'b0, 16'h0000, 1'b0);
    chk("code3_again", 16'(code), 16'h0003);
    step(1'b0, 16'h0000, 1'b1);

    // enable gating and spurious ack
    repeat (4) step(1'b0, 16'hFFFF, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);

    // async reset mid-operation
    step(1'b1, 16'h00F0, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("code4", 16'(code), 16'h0004);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 16'h0000, 1'b0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      logic [15:0] r;
      r = 16'h0000;
      if ($urandom_range(0, 3) == 0) r = 16'($urandom);
      else if ($urandom_range(0, 1) == 0) r = 16'h0001 << $urandom_range(0, 15);
      step(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
